// File: rtl/snake_pkg.sv
// Shared constants for the snake design: direction encoding, PS/2 set-2 scan codes
// and the receiver's bit-level FSM state encoding.
package snake_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    localparam logic [7:0] SC_E0  = 8'hE0;
    localparam logic [7:0] SC_F0  = 8'hF0;
    localparam logic [7:0] SC_ESC = 8'h76;

    localparam logic [7:0] SC_W = 8'h1D;
    localparam logic [7:0] SC_D = 8'h23;
    localparam logic [7:0] SC_S = 8'h1B;
    localparam logic [7:0] SC_A = 8'h1C;

    // Arrow keys arrive with an E0 prefix.
    localparam logic [7:0] SC_ARROW_UP    = 8'h75;
    localparam logic [7:0] SC_ARROW_RIGHT = 8'h74;
    localparam logic [7:0] SC_ARROW_DOWN  = 8'h72;
    localparam logic [7:0] SC_ARROW_LEFT  = 8'h6B;

    localparam logic RX_IDLE  = 1'b0;
    localparam logic RX_SHIFT = 1'b1;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizer, registered falling-edge strobe, bit FSM,
// odd-parity/stop check and inter-edge timeout. Strobes are combinational from flops.
module ps2_frame_rx
    import snake_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_prev;
    logic                   fall_q;
    logic                   dat_q;
    logic                   state;
    logic [3:0]             bit_cnt;
    logic [8:0]             shreg;
    logic [CW-1:0]          cnt;

    logic clk_s;
    logic dat_s;
    logic stop_edge;
    logic frame_ok;
    logic timeout;

    assign clk_s = clk_sync[SYNC_STAGES-1];
    assign dat_s = dat_sync[SYNC_STAGES-1];

    // Data is delayed alongside the registered edge strobe so it is sampled at the same point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
            fall_q   <= 1'b0;
            dat_q    <= 1'b1;
        end else begin
            clk_sync[0] <= ps2_clk;
            dat_sync[0] <= ps2_data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                clk_sync[i] <= clk_sync[i-1];
                dat_sync[i] <= dat_sync[i-1];
            end
            clk_prev <= clk_s;
            fall_q   <= clk_prev & ~clk_s;
            dat_q    <= dat_s;
        end
    end

    assign stop_edge  = fall_q && (state == RX_SHIFT) && (bit_cnt == 4'd9);
    assign frame_ok   = (^shreg) && dat_q;
    assign timeout    = (state == RX_SHIFT) && !fall_q && (cnt == CW'(TIMEOUT_CYCLES));
    assign data_byte  = shreg[7:0];
    assign byte_valid = stop_edge && frame_ok;
    assign frame_err  = (stop_edge && !frame_ok) || timeout;

    // bit_cnt 0..7 are data, 8 is parity, 9 is the stop bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RX_IDLE;
            bit_cnt <= 4'd0;
            shreg   <= 9'd0;
            cnt     <= '0;
        end else if (fall_q) begin
            cnt <= '0;
            if (state == RX_IDLE) begin
                if (!dat_q) begin
                    state   <= RX_SHIFT;
                    bit_cnt <= 4'd0;
                end
            end else if (bit_cnt < 4'd9) begin
                shreg   <= {dat_q, shreg[8:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end else begin
                state <= RX_IDLE;
            end
        end else if (state == RX_SHIFT) begin
            if (cnt == CW'(TIMEOUT_CYCLES)) begin
                state <= RX_IDLE;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/ps2_direction_decoder.sv
// PS/2 keyboard to snake direction decoder: byte-level E0/F0 handling and
// registered dir, dir_valid, esc and frame_err outputs.
module ps2_direction_decoder
    import snake_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       PS2CLK,
    input  logic       PS2Data,
    output logic [1:0] dir,
    output logic       dir_valid,
    output logic       esc,
    output logic       frame_err
);

    logic [7:0] data_byte;
    logic       byte_valid;
    logic       rx_err;
    logic       ext;
    logic       brk;

    ps2_frame_rx #(
        .SYNC_STAGES   (SYNC_STAGES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (PS2CLK),
        .ps2_data  (PS2Data),
        .data_byte (data_byte),
        .byte_valid(byte_valid),
        .frame_err (rx_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir       <= DIR_RIGHT;
            dir_valid <= 1'b0;
            esc       <= 1'b0;
            frame_err <= 1'b0;
            ext       <= 1'b0;
            brk       <= 1'b0;
        end else begin
            dir_valid <= 1'b0;
            frame_err <= rx_err;
            if (byte_valid) begin
                if (data_byte == SC_E0) begin
                    ext <= 1'b1;
                end else if (data_byte == SC_F0) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    // Releases only matter for ESC; direction keys are edge-triggered on make.
                    if (brk) begin
                        if (data_byte == SC_ESC) esc <= 1'b0;
                    end else if (ext) begin
                        case (data_byte)
                            SC_ARROW_UP:    begin dir <= DIR_UP;    dir_valid <= 1'b1; end
                            SC_ARROW_RIGHT: begin dir <= DIR_RIGHT; dir_valid <= 1'b1; end
                            SC_ARROW_DOWN:  begin dir <= DIR_DOWN;  dir_valid <= 1'b1; end
                            SC_ARROW_LEFT:  begin dir <= DIR_LEFT;  dir_valid <= 1'b1; end
                            default: ;
                        endcase
                    end else begin
                        case (data_byte)
                            SC_W:    begin dir <= DIR_UP;    dir_valid <= 1'b1; end
                            SC_D:    begin dir <= DIR_RIGHT; dir_valid <= 1'b1; end
                            SC_S:    begin dir <= DIR_DOWN;  dir_valid <= 1'b1; end
                            SC_A:    begin dir <= DIR_LEFT;  dir_valid <= 1'b1; end
                            SC_ESC:  esc <= 1'b1;
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Bench for ps2_direction_decoder: directed scenarios plus random scan-code frames,
// with a scoreboard of expected output pulses checked by an independent monitor.
module tb_ps2_direction_decoder;

    localparam int SYNC    = 2;
    localparam int TOUT    = 400;
    localparam int LAT     = SYNC + 2;

    logic       clk;
    logic       rst;
    logic       PS2CLK;
    logic       PS2Data;
    logic [1:0] dir;
    logic       dir_valid;
    logic       esc;
    logic       frame_err;

    ps2_direction_decoder #(
        .SYNC_STAGES   (SYNC),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .PS2CLK   (PS2CLK),
        .PS2Data  (PS2Data),
        .dir      (dir),
        .dir_valid(dir_valid),
        .esc      (esc),
        .frame_err(frame_err)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Scoreboard entry: {expected cycle[31:0], is_err, dir[1:0], esc}
    logic [35:0] exp_q[$];

    // Reference model state, kept at the scan-code level.
    bit         m_ext;
    bit         m_brk;
    logic [1:0] m_dir;
    bit         m_esc;
    int         last_fall;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_ext = 0;
        m_brk = 0;
        m_dir = 2'b01;
        m_esc = 0;
    endtask

    function automatic int dir_of(input logic [7:0] b, input bit ext);
        if (!ext) begin
            if (b == 8'h1D) return 0;
            if (b == 8'h23) return 1;
            if (b == 8'h1B) return 2;
            if (b == 8'h1C) return 3;
        end else begin
            if (b == 8'h75) return 0;
            if (b == 8'h74) return 1;
            if (b == 8'h72) return 2;
            if (b == 8'h6B) return 3;
        end
        return -1;
    endfunction

    // Applies one accepted byte to the model; pushes a dir_valid event if one is due.
    task automatic model_byte(input logic [7:0] b, input int out_cyc);
        int d;
        if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            if (m_brk) begin
                if (b == 8'h76) m_esc = 0;
            end else begin
                d = dir_of(b, m_ext);
                if (d >= 0) begin
                    m_dir = 2'(d);
                    exp_q.push_back({32'(out_cyc), 1'b0, m_dir, m_esc});
                end else if (!m_ext && b == 8'h76) begin
                    m_esc = 1;
                end
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    // driver: sends nbits of a frame; on the 11th fall the expected outcome is queued.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int nbits, input int h);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            PS2Data = bits[i];
            repeat (h) @(negedge clk);
            PS2CLK = 1'b0;
            last_fall = cyc;
            if (i == 10) begin
                if (bad_par || bad_stop)
                    exp_q.push_back({32'(last_fall + LAT), 1'b1, m_dir, m_esc});
                else
                    model_byte(b, last_fall + LAT);
            end
            repeat (h) @(negedge clk);
            PS2CLK = 1'b1;
        end
        repeat (h) @(negedge clk);
    endtask

    task automatic good(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 11, 10);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_dir"}, 32'(dir), 32'(m_dir));
        check({tag, "_esc"}, 32'(esc), 32'(m_esc));
    endtask

    task automatic wait_drain(input string tag);
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // monitor: pops the scoreboard whenever the DUT presents a pulse
    bit prev_pulse = 0;
    always @(negedge clk) begin
        logic [35:0] e;
        if (!rst) begin
            if (dir_valid && frame_err) check("pulse_overlap", 32'd1, 32'd0);
            if (dir_valid || frame_err) begin
                if (prev_pulse) check("pulse_back_to_back", 32'd1, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {30'd0, frame_err, dir_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", 32'(frame_err), 32'(e[3]));
                    check("pulse_cycle", 32'(cyc), e[35:4]);
                    check("pulse_dir", 32'(dir), 32'(e[2:1]));
                    check("pulse_esc", 32'(esc), 32'(e[0]));
                end
            end
            prev_pulse = dir_valid || frame_err;
        end else begin
            prev_pulse = 0;
        end
    end

    logic [7:0] pool [12];

    initial begin
        pool = '{8'h1D, 8'h23, 8'h1B, 8'h1C, 8'h76, 8'hE0, 8'hF0,
                 8'h75, 8'h74, 8'h72, 8'h6B, 8'h00};
        rst     = 1'b1;
        PS2CLK  = 1'b1;
        PS2Data = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        check("rst_dir", 32'(dir), 32'd1);
        check("rst_dir_valid", 32'(dir_valid), 32'd0);
        check("rst_esc", 32'(esc), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        good(8'h1D);
        wait_drain("w_make");
        check_state("w_make");

        good(8'hE0); good(8'h74);
        wait_drain("arrow_right");
        check_state("arrow_right");
        good(8'hE0); good(8'hF0); good(8'h74);
        wait_drain("arrow_release");
        check("arrow_release_dir", 32'(dir), 32'd1);

        send_frame(8'h1C, 1'b1, 1'b0, 11, 10);
        wait_drain("bad_parity");
        check("bad_parity_dir", 32'(dir), 32'd1);
        good(8'h1B);
        wait_drain("after_err");
        check("after_err_dir", 32'(dir), 32'd2);

        send_frame(8'h23, 1'b0, 1'b0, 5, 10);
        exp_q.push_back({32'(last_fall + LAT + 1 + TOUT), 1'b1, m_dir, m_esc});
        repeat (TOUT + 20) @(negedge clk);
        wait_drain("timeout");
        good(8'h23);
        wait_drain("after_timeout");
        check("after_timeout_dir", 32'(dir), 32'd1);

        good(8'h76);
        wait_drain("esc_make");
        check("esc_make", 32'(esc), 32'd1);
        good(8'hF0); good(8'h76);
        wait_drain("esc_break");
        check("esc_break", 32'(esc), 32'd0);

        send_frame(8'h1D, 1'b0, 1'b0, 6, 10);
        @(negedge clk);
        rst = 1'b1;
        PS2CLK = 1'b1;
        PS2Data = 1'b1;
        model_reset();
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("mid_rst_dir", 32'(dir), 32'd1);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        good(8'h1C);
        wait_drain("post_rst");
        check("post_rst_dir", 32'(dir), 32'd3);

        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            int r;
            b = pool[$urandom_range(0, 11)];
            if (b == 8'h00) b = 8'($urandom_range(0, 255));
            r = $urandom_range(0, 9);
            send_frame(b, r == 0, r == 1, 11, $urandom_range(6, 14));
            wait_drain("rand");
            check_state("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        repeat (90000) @(posedge clk);
        failures++;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
